// File: rtl/spi_cmd.sv
// SPI command decoder: turns the spi_byte receive stream into memory-bus
// read/write requests in the system clock domain.
module spi_cmd (
  input  logic       clk_sys_i,
  input  logic       reset_i,
  input  logic       spi_cs_ni,
  input  logic [7:0] spi_rx_byte_i,
  input  logic       spi_rx_valid_i,
  output logic [7:0] spi_tx_byte_o,
  output logic [15:0] addr_o,
  output logic [7:0] data_o,
  output logic       we_o,
  output logic       pending_o,
  input  logic       done_i,
  input  logic [7:0] data_i,
  output logic       overrun_o
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] OP_WRITE      = 2'b00;
  localparam logic [OP_W-1:0] OP_READ       = 2'b01;
  localparam logic [OP_W-1:0] OP_WRITE_NEXT = 2'b10;
  localparam logic [OP_W-1:0] OP_READ_NEXT  = 2'b11;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA,
    ST_PENDING
  } state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [BYTE_W-1:0]   data_d;
  logic [BYTE_W-1:0]   tx_d;
  logic                we_d;
  logic                pending_d;
  logic                overrun_d;

  logic [1:0] rx_sync_q;
  logic       rx_prev_q;
  logic       byte_evt_q;
  logic [1:0] cs_sync_q;
  logic       cs_prev_q;
  logic       cs_rise_q;
  logic       cs_fall_q;

  // 2-FF synchronizers plus a registered edge detect, so a byte event lands
  // three cycles after valid rises while the byte is still held stable.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      rx_sync_q  <= 2'b00;
      rx_prev_q  <= 1'b0;
      byte_evt_q <= 1'b0;
      cs_sync_q  <= 2'b11;
      cs_prev_q  <= 1'b1;
      cs_rise_q  <= 1'b0;
      cs_fall_q  <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], spi_rx_valid_i};
      rx_prev_q  <= rx_sync_q[1];
      byte_evt_q <= rx_sync_q[1] & ~rx_prev_q;
      cs_sync_q  <= {cs_sync_q[0], spi_cs_ni};
      cs_prev_q  <= cs_sync_q[1];
      cs_rise_q  <= cs_sync_q[1] & ~cs_prev_q;
      cs_fall_q  <= ~cs_sync_q[1] & cs_prev_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q       <= ST_CMD;
      op_q          <= OP_WRITE;
      addr_o        <= '0;
      data_o        <= '0;
      we_o          <= 1'b0;
      pending_o     <= 1'b0;
      spi_tx_byte_o <= '0;
      overrun_o     <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_o        <= addr_d;
      data_o        <= data_d;
      we_o          <= we_d;
      pending_o     <= pending_d;
      spi_tx_byte_o <= tx_d;
      overrun_o     <= overrun_d;
    end
  end

  // Command parser; a byte arriving while a request is outstanding is lost.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_o;
    data_d    = data_o;
    we_d      = we_o;
    tx_d      = spi_tx_byte_o;
    overrun_d = overrun_o;

    if (cs_fall_q) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      ST_CMD: begin
        if (byte_evt_q) begin
          op_d = spi_rx_byte_i[7:6];
          unique case (spi_rx_byte_i[7:6])
            OP_WRITE, OP_READ: state_d = ST_ADDR_HI;
            OP_WRITE_NEXT: begin
              addr_d  = addr_o + ADDR_W'(1);
              state_d = ST_DATA;
            end
            OP_READ_NEXT: begin
              addr_d  = addr_o + ADDR_W'(1);
              we_d    = 1'b0;
              state_d = ST_PENDING;
            end
            default: state_d = ST_CMD;
          endcase
        end
      end

      ST_ADDR_HI: begin
        if (cs_rise_q) begin
          state_d = ST_CMD;
        end else if (byte_evt_q) begin
          addr_d[15:8] = spi_rx_byte_i;
          state_d      = ST_ADDR_LO;
        end
      end

      ST_ADDR_LO: begin
        if (cs_rise_q) begin
          state_d = ST_CMD;
        end else if (byte_evt_q) begin
          addr_d[7:0] = spi_rx_byte_i;
          if (op_q == OP_READ) begin
            we_d    = 1'b0;
            state_d = ST_PENDING;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (cs_rise_q) begin
          state_d = ST_CMD;
        end else if (byte_evt_q) begin
          data_d  = spi_rx_byte_i;
          we_d    = 1'b1;
          state_d = ST_PENDING;
        end
      end

      ST_PENDING: begin
        if (byte_evt_q) begin
          overrun_d = 1'b1;
        end
        if (done_i) begin
          if (!we_o) begin
            tx_d = data_i;
          end
          state_d = ST_CMD;
        end
      end

      default: state_d = ST_CMD;
    endcase

    pending_d = (state_d == ST_PENDING);
  end

endmodule

// File: tb/tb_spi_cmd.sv
// Randomized self-checking bench for spi_cmd against a command-level model.
module tb_spi_cmd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_n = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic        pending;
  logic        done = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic        overrun;

  spi_cmd dut (
    .clk_sys_i      (clk),
    .reset_i        (reset),
    .spi_cs_ni      (cs_n),
    .spi_rx_byte_i  (rx_byte),
    .spi_rx_valid_i (rx_valid),
    .spi_tx_byte_o  (tx_byte),
    .addr_o         (addr),
    .data_o         (wdata),
    .we_o           (we),
    .pending_o      (pending),
    .done_i         (done),
    .data_i         (rdata),
    .overrun_o      (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: what the bus should see, independent of parser internals.
  logic [15:0] addr_m = 16'h0000;
  logic [7:0]  data_m = 8'h00;
  logic [7:0]  tx_m   = 8'h00;
  logic        ovr_m  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One SPI byte: valid held 6 cycles, low 4; lat = first cycle pending seen.
  task automatic send_byte(input logic [7:0] b, output int lat);
    lat      = 0;
    rx_byte  = b;
    rx_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick;
      if (i == 6) rx_valid = 1'b0;
      if (pending && lat == 0) lat = i;
    end
  endtask

  task automatic cs_cycle(output bit saw_pend);
    saw_pend = 1'b0;
    cs_n = 1'b1;
    repeat (6) begin
      tick;
      if (pending) saw_pend = 1'b1;
    end
    cs_n = 1'b0;
    repeat (6) begin
      tick;
      if (pending) saw_pend = 1'b1;
    end
    ovr_m = 1'b0;
  endtask

  function automatic int nbytes(input logic [1:0] op);
    case (op)
      2'd0:    return 4;
      2'd1:    return 3;
      2'd2:    return 2;
      default: return 1;
    endcase
  endfunction

  task automatic check_req(input logic [15:0] ea, input logic [7:0] ed, input logic ew);
    chk("addr", 32'(addr), 32'(ea));
    chk("wdata", 32'(wdata), 32'(ed));
    chk("we", 32'(we), 32'(ew));
  endtask

  // Bus slave side: hold a random number of cycles, then complete.
  task automatic finish_req(input logic [15:0] ea, input logic [7:0] ed, input logic ew,
                            input logic [7:0] rd);
    int n = 0;
    int hold;
    while (!pending && n < 20) begin
      tick;
      n++;
    end
    chk("pend_rise", 32'(pending), 32'd1);
    hold = $urandom_range(0, 4);
    for (int i = 0; i < hold; i++) begin
      check_req(ea, ed, ew);
      tick;
      chk("pend_hold", 32'(pending), 32'd1);
    end
    check_req(ea, ed, ew);
    rdata = rd;
    done  = 1'b1;
    tick;
    done  = 1'b0;
    rdata = 8'($urandom);
    if (!ew) tx_m = rd;
    chk("pend_fall", 32'(pending), 32'd0);
    chk("tx_byte", 32'(tx_byte), 32'(tx_m));
  endtask

  // mode: 0 plain, 1 extra byte while pending, 2 byte in the done cycle, 3 reset while pending
  task automatic run_cmd(input logic [31:0] w, input int mode, input logic [7:0] rd);
    logic [7:0]  b [4];
    logic [1:0]  op;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ew;
    int          nb;
    int          lat;
    b[0] = w[31:24];
    b[1] = w[23:16];
    b[2] = w[15:8];
    b[3] = w[7:0];
    op = b[0][7:6];
    nb = nbytes(op);
    case (op)
      2'd0: begin addr_m = {b[1], b[2]}; data_m = b[3]; ew = 1'b1; end
      2'd1: begin addr_m = {b[1], b[2]}; ew = 1'b0; end
      2'd2: begin addr_m = addr_m + 16'd1; data_m = b[1]; ew = 1'b1; end
      default: begin addr_m = addr_m + 16'd1; ew = 1'b0; end
    endcase
    ea = addr_m;
    ed = data_m;
    for (int k = 0; k < nb; k++) begin
      send_byte(b[k], lat);
      if (k < nb - 1) chk("early_req", 32'(lat), 32'd0);
      else            chk("latency", 32'(lat), 32'd4);
    end
    case (mode)
      1: begin
        send_byte(8'($urandom), lat);
        ovr_m = 1'b1;
        chk("ovr_set", 32'(overrun), 32'd1);
        finish_req(ea, ed, ew, rd);
      end
      2: begin
        check_req(ea, ed, ew);
        rx_byte  = 8'($urandom);
        rx_valid = 1'b1;
        repeat (3) tick;
        chk("pend_pre", 32'(pending), 32'd1);
        rdata = rd;
        done  = 1'b1;
        tick;
        done  = 1'b0;
        if (!ew) tx_m = rd;
        ovr_m = 1'b1;
        chk("coll_pend", 32'(pending), 32'd0);
        chk("coll_tx", 32'(tx_byte), 32'(tx_m));
        chk("coll_ovr", 32'(overrun), 32'd1);
        repeat (2) tick;
        rx_valid = 1'b0;
        repeat (4) tick;
      end
      3: begin
        chk("pend_pre", 32'(pending), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        addr_m = 16'h0000;
        data_m = 8'h00;
        tx_m   = 8'h00;
        ovr_m  = 1'b0;
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data", 32'(wdata), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_tx", 32'(tx_byte), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        repeat (4) tick;
      end
      default: finish_req(ea, ed, ew, rd);
    endcase
  endtask

  // Send the first nsent bytes of a command, then drop CS.
  task automatic abort_cmd(input logic [31:0] w, input int nsent);
    logic [7:0] b [4];
    int lat;
    bit saw;
    b[0] = w[31:24];
    b[1] = w[23:16];
    b[2] = w[15:8];
    b[3] = w[7:0];
    for (int k = 0; k < nsent; k++) begin
      send_byte(b[k], lat);
      chk("abort_early", 32'(lat), 32'd0);
    end
    if (b[0][7:6] == 2'd2) begin
      addr_m = addr_m + 16'd1;
    end else begin
      if (nsent >= 2) addr_m[15:8] = b[1];
      if (nsent >= 3) addr_m[7:0]  = b[2];
    end
    cs_cycle(saw);
    chk("abort_req", 32'(saw), 32'd0);
  endtask

  task automatic idle_done;
    rdata = 8'($urandom);
    done  = 1'b1;
    tick;
    done  = 1'b0;
    chk("idle_pend", 32'(pending), 32'd0);
    chk("idle_tx", 32'(tx_byte), 32'(tx_m));
  endtask

  initial begin
    bit saw;
    logic [31:0] w;
    logic [1:0]  op;
    int          r;
    int          m;

    repeat (3) tick;
    chk("reset_addr", 32'(addr), 32'd0);
    chk("reset_data", 32'(wdata), 32'd0);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_pend", 32'(pending), 32'd0);
    chk("reset_tx", 32'(tx_byte), 32'd0);
    chk("reset_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;
    cs_n  = 1'b0;
    repeat (6) tick;

    run_cmd(32'h0080_005A, 0, 8'hA5);
    run_cmd(32'h40E8_1000, 0, 8'h3C);
    run_cmd(32'hC000_0000, 0, 8'h7E);
    run_cmd(32'h40FF_FF00, 0, 8'h99);
    run_cmd(32'h8011_0000, 0, 8'h55);
    chk("wrap_addr", 32'(addr), 32'h0000);

    run_cmd(32'h4012_3400, 1, 8'h21);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    cs_cycle(saw);
    chk("ovr_clear", 32'(overrun), 32'd0);
    run_cmd(32'hC000_0000, 2, 8'h42);
    cs_cycle(saw);
    chk("ovr_clear2", 32'(overrun), 32'd0);

    abort_cmd(32'h0012_0000, 2);
    run_cmd(32'h4000_0100, 0, 8'h6B);

    run_cmd(32'h4ABC_DE00, 3, 8'h00);
    run_cmd(32'hC000_0000, 0, 8'h17);

    for (int it = 0; it < 60; it++) begin
      w  = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0) begin
        op = 2'($urandom_range(0, 2));
        w[31:30] = op;
        abort_cmd(w, $urandom_range(1, nbytes(op) - 1));
      end else if (r == 1) begin
        cs_cycle(saw);
        chk("cs_idle", 32'(saw), 32'd0);
      end else if (r == 2) begin
        idle_done;
      end else begin
        m = $urandom_range(0, 9);
        run_cmd(w, (m == 0) ? 1 : (m == 1) ? 2 : 0, 8'($urandom));
      end
      chk("overrun", 32'(overrun), 32'(ovr_m));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd.md
# spi_cmd

Consumes the byte stream from the SPI peripheral byte receiver (`spi_byte`) and decodes it into memory-bus read/write requests in the system clock domain. It is the stage directly downstream of `spi_byte`. It synchronizes that block's SCK-domain `rx_valid`/`cs_n`, parses 1–4 byte commands, and issues one bus request per command over a pending/done handshake. Read results are returned on `spi_tx_byte_o`, which feeds `spi_byte.tx_byte_i`, so the MCU shifts them out on its next byte transfer.

## Interface
- No parameters.
- `clk_sys_i` in 1: system clock; all logic is on the rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `spi_cs_ni` in 1: SPI chip select, SCK/async domain, active-low; synchronized internally.
- `spi_rx_byte_i` in 8: received byte from `spi_byte`.
- `spi_rx_valid_i` in 1: byte-valid level from `spi_byte`, SCK domain; synchronized internally.
- `spi_tx_byte_o` out 8: byte returned to the MCU on the next transfer.
- `addr_o` out 16: bus address.
- `data_o` out 8: write data.
- `we_o` out 1: 1 = write, 0 = read; valid while `pending_o` = 1.
- `pending_o` out 1: bus request outstanding.
- `done_i` in 1: bus completion strobe, one cycle, sampled only while `pending_o` = 1.
- `data_i` in 8: read data; valid in the cycle `done_i` = 1.
- `overrun_o` out 1: sticky error flag; cleared by reset or by a CS assertion edge.

## Operation
- Synchronizers: 2-FF synchronizer on `spi_rx_valid_i` and on `spi_cs_ni`.
  - A byte event is the rising edge of synchronized valid.
  - `spi_rx_byte_i` is captured in the byte-event cycle. The upstream stage guarantees the byte is stable for at least 4 `clk_sys_i` cycles after valid rises.
- Command byte `cmd[7:6]` opcode; `cmd[5:0]` is ignored.
  - `00` WRITE: followed by addr_hi, addr_lo, data.
  - `01` READ: followed by addr_hi, addr_lo.
  - `10` WRITE_NEXT: followed by data; the address is the previous address + 1.
  - `11` READ_NEXT: no operand bytes; the address is the previous address + 1.
- States: CMD, ADDR_HI, ADDR_LO, DATA, PENDING.
  - CMD, on byte: latch the opcode.
    - 00 or 01 → ADDR_HI.
    - 10 → DATA with `addr_o` += 1.
    - 11 → PENDING with `addr_o` += 1 and `we_o` = 0.
  - ADDR_HI, on byte: `addr_o[15:8]` <= byte → ADDR_LO.
  - ADDR_LO, on byte: `addr_o[7:0]` <= byte.
    - READ → PENDING with `we_o` = 0.
    - WRITE → DATA.
  - DATA, on byte: `data_o` <= byte, `we_o` = 1 → PENDING.
  - PENDING, on `done_i`: if the request is a read, `spi_tx_byte_o` <= `data_i`. Then → CMD.
- Address increment is 16-bit modulo: FFFF + 1 = 0000. The address persists across commands and across CS cycles.
- Byte event while in PENDING, including the cycle in which `done_i` = 1: the byte is dropped and `overrun_o` <= 1.
- Synchronized CS deassert (rising edge of `spi_cs_ni`) in ADDR_HI, ADDR_LO or DATA:
  - Return to CMD and discard the partial command.
  - `addr_o` keeps any bytes already latched.
- CS deassert while in PENDING: the request is not aborted. Completion proceeds normally, then → CMD.
- Synchronized CS assert (falling edge): `overrun_o` <= 0. In CMD, the state is unchanged.
- `done_i` outside PENDING: ignored.

## Timing
- Reset values: state CMD; `addr_o` 0000; `data_o` 00; `we_o` 0; `pending_o` 0; `spi_tx_byte_o` 00; `overrun_o` 0.
- Byte latency: `spi_rx_valid_i` rising at cycle 0 → sync stages at cycles 1 and 2 → byte event/decode in cycle 3.
- `pending_o` asserts in the cycle after the final byte event (cycle 4). `addr_o`, `data_o` and `we_o` are stable from that cycle until `pending_o` falls.
- `pending_o` falls in the cycle after `done_i`. `spi_tx_byte_o` updates in that same cycle.
- Bus latency is unbounded; `pending_o` holds until `done_i`.
- A new command may begin in the cycle after `pending_o` falls.
- Reset mid-operation takes effect at the next clock edge and drops any outstanding request. The bus arbiter sees `pending_o` fall without `done_i`.

## Test plan
- WRITE: send 00,80,00,5A → one request with `addr_o` = 8000, `data_o` = 5A, `we_o` = 1. `pending_o` holds until `done_i`; `spi_tx_byte_o` stays 00.
- READ then READ_NEXT: send 40,E8,10; return `data_i` = 3C; then send C0 and return 7E.
  - `addr_o` = E810, then E811.
  - `spi_tx_byte_o` = 3C, then 7E.
- Wrap: READ at FFFF, then WRITE_NEXT with 11 → the second request has `addr_o` = 0000, `data_o` = 11, `we_o` = 1.
- Overrun: send a byte while `pending_o` = 1, and separately send one in the same cycle as `done_i`.
  - Each byte is dropped and `overrun_o` = 1.
  - The next CS assert clears `overrun_o`.
- CS abort: send 00,12 then deassert CS, reassert it, and send 40,00,01.
  - No request is issued for the aborted command.
  - Then a read at 0001 is issued.
- Reset while `pending_o` = 1 → the next cycle shows all outputs at their reset values, and the state is CMD.
